multdiv_ctrl: RTL and testbench

Sequencer for the shared multi-cycle multiply/divide unit in the processor's execute stage. It detects R-type `mul`/`div` instructions, pulses the unit's start strobe, and stalls the pipeline until the result returns. It then presents one register-file writeback. Arithmetic exceptions and timeouts are redirected to `$r30` (rstatus).

---
 rtl/multdiv_ctrl.sv | 123 ++++++++++++
 tb/tb_multdiv_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle mul/div unit.
// Issues the start strobe, stalls until the result arrives, then writes back once.
module multdiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int MUL_EXC = 4,
  parameter int DIV_EXC = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             insn_valid,
  input  logic [4:0]       opcode,
  input  logic [4:0]       func,
  input  logic [4:0]       rd,
  input  logic             flush,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_rdy,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

  state_e          state_q;
  logic            div_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt_q;

  logic            is_mul;
  logic            is_div;
  logic            hit;
  logic            fin;
  logic            exc_d;
  logic            wb_valid_d;
  logic [4:0]      wb_rd_d;
  logic [WIDTH-1:0] wb_data_d;

  assign is_mul = func == 5'b00110;
  assign is_div = func == 5'b00111;
  assign hit    = insn_valid & (opcode == 5'b00000)
                & (is_mul | is_div) & ~flush;

  assign stall = ((state_q == IDLE) & hit)
               | (state_q == START) | (state_q == WAIT);
  assign busy  = state_q != IDLE;

  // md_rdy wins over a coincident timeout
  assign fin = md_rdy | (cnt_q == CNT_LAST);

  always_comb begin
    exc_d      = md_rdy ? md_exception : 1'b1;
    wb_rd_d    = rd_q;
    wb_data_d  = md_result;
    wb_valid_d = rd_q != 5'd0;
    if (exc_d) begin
      wb_rd_d    = 5'd30;
      wb_data_d  = div_q ? WIDTH'(DIV_EXC) : WIDTH'(MUL_EXC);
      wb_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            state_q   <= START;
            div_q     <= is_div;
            rd_q      <= rd;
            ctrl_MULT <= is_mul;
            ctrl_DIV  <= is_div;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (fin) begin
            state_q  <= DONE;
            wb_valid <= wb_valid_d;
            wb_rd    <= wb_rd_d;
            wb_data  <= wb_data_d;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // same instruction still visible: no re-trigger here
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl.
// Negedge monitor tallies strobes, stall cycles and writebacks.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        insn_valid;
  logic [4:0]  opcode;
  logic [4:0]  func;
  logic [4:0]  rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_rdy;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  localparam logic [4:0] F_MUL = 5'b00110;
  localparam logic [4:0] F_DIV = 5'b00111;

  multdiv_ctrl #(
    .WIDTH(32), .TIMEOUT(64), .MUL_EXC(4), .DIV_EXC(5)
  ) dut (
    .clock(clock), .reset(reset),
    .insn_valid(insn_valid), .opcode(opcode),
    .func(func), .rd(rd), .flush(flush),
    .md_result(md_result), .md_exception(md_exception),
    .md_rdy(md_rdy),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int s_stall = 0;
  int s_mul = 0;
  int s_div = 0;
  int s_wb = 0;
  logic [4:0]  wrd_log [16];
  logic [31:0] wdat_log [16];
  int          wcyc_log [16];

  always @(negedge clock) begin
    if (stall) s_stall <= s_stall + 1;
    if (ctrl_MULT) s_mul <= s_mul + 1;
    if (ctrl_DIV) s_div <= s_div + 1;
    if (wb_valid) begin
      if (s_wb < 16) begin
        wrd_log[s_wb]  <= wb_rd;
        wdat_log[s_wb] <= wb_data;
        wcyc_log[s_wb] <= cyc;
      end
      s_wb <= s_wb + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int b_stall, b_mul, b_div, b_wb, hit_cyc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    b_stall = s_stall;
    b_mul   = s_mul;
    b_div   = s_div;
    b_wb    = s_wb;
  endtask

  task automatic idle_in();
    insn_valid = 0; opcode = 0; func = 0; rd = 0;
    flush = 0; md_rdy = 0; md_result = 0; md_exception = 0;
  endtask

  // n WAIT cycles; md_rdy on the last one when rdy_en
  task automatic op(input logic [4:0] f, input logic [4:0] r,
                    input int n, input logic rdy_en,
                    input logic [31:0] res, input logic ex);
    int total;
    total = n + 2;
    insn_valid = 1; opcode = 0; func = f; rd = r;
    hit_cyc = cyc;
    for (int i = 1; i <= total; i++) begin
      step();
      md_rdy = rdy_en && (i == total - 1);
      md_result = res;
      md_exception = ex;
    end
    step();
    idle_in();
    step();
  endtask

  initial begin
    idle_in();
    reset = 1;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mul", 32'(ctrl_MULT), 0);
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_wbrd", 32'(wb_rd), 0);
    chk("rst_wbdat", wb_data, 0);
    reset = 0;
    step();

    // mul rd=7, rdy 4 cycles after strobe
    snap();
    op(F_MUL, 5'd7, 4, 1'b1, 32'h15, 1'b0);
    chk("t1_mul", 32'(s_mul - b_mul), 1);
    chk("t1_div", 32'(s_div - b_div), 0);
    chk("t1_stall", 32'(s_stall - b_stall), 6);
    chk("t1_nwb", 32'(s_wb - b_wb), 1);
    chk("t1_wbrd", 32'(wrd_log[b_wb]), 7);
    chk("t1_wbdat", wdat_log[b_wb], 32'h15);
    chk("t1_lat", 32'(wcyc_log[b_wb] - hit_cyc), 6);
    chk("t1_busy", 32'(busy), 0);

    // div rd=3 with exception
    snap();
    op(F_DIV, 5'd3, 2, 1'b1, 32'h99, 1'b1);
    chk("t2_div", 32'(s_div - b_div), 1);
    chk("t2_mul", 32'(s_mul - b_mul), 0);
    chk("t2_nwb", 32'(s_wb - b_wb), 1);
    chk("t2_wbrd", 32'(wrd_log[b_wb]), 30);
    chk("t2_wbdat", wdat_log[b_wb], 5);

    // mul timeout: 64 WAIT cycles then forced exception
    snap();
    op(F_MUL, 5'd8, 64, 1'b0, 32'h0, 1'b0);
    chk("t3_stall", 32'(s_stall - b_stall), 66);
    chk("t3_nwb", 32'(s_wb - b_wb), 1);
    chk("t3_wbrd", 32'(wrd_log[b_wb]), 30);
    chk("t3_wbdat", wdat_log[b_wb], 4);
    chk("t3_lat", 32'(wcyc_log[b_wb] - hit_cyc), 66);

    // flush in second WAIT cycle, late md_rdy
    snap();
    insn_valid = 1; func = F_MUL; rd = 5'd9;
    step();
    step();
    step();
    flush = 1;
    step();
    idle_in();
    #1;
    chk("t4_stall", 32'(stall), 0);
    chk("t4_busy", 32'(busy), 0);
    step();
    md_rdy = 1; md_result = 32'h77;
    step();
    idle_in();
    step();
    step();
    chk("t4_nwb", 32'(s_wb - b_wb), 0);
    chk("t4_stall_n", 32'(s_stall - b_stall), 4);
    chk("t4_mul", 32'(s_mul - b_mul), 1);

    // back-to-back mul rd=5 then div rd=6
    snap();
    insn_valid = 1; func = F_MUL; rd = 5'd5;
    step();
    step();
    step();
    md_rdy = 1; md_result = 32'h11;
    step();
    md_rdy = 0;
    step();
    func = F_DIV; rd = 5'd6;
    step();
    step();
    step();
    md_rdy = 1; md_result = 32'h22;
    step();
    md_rdy = 0;
    step();
    idle_in();
    step();
    chk("t5_mul", 32'(s_mul - b_mul), 1);
    chk("t5_div", 32'(s_div - b_div), 1);
    chk("t5_nwb", 32'(s_wb - b_wb), 2);
    chk("t5_rd0", 32'(wrd_log[b_wb]), 5);
    chk("t5_dat0", wdat_log[b_wb], 32'h11);
    chk("t5_rd1", 32'(wrd_log[b_wb+1]), 6);
    chk("t5_dat1", wdat_log[b_wb+1], 32'h22);
    chk("t5_gap", 32'(wcyc_log[b_wb+1] - wcyc_log[b_wb]), 5);
    chk("t5_stall", 32'(s_stall - b_stall), 8);

    // mul to rd=0: no writeback
    snap();
    op(F_MUL, 5'd0, 2, 1'b1, 32'h33, 1'b0);
    chk("t6_mul", 32'(s_mul - b_mul), 1);
    chk("t6_nwb", 32'(s_wb - b_wb), 0);
    chk("t6_stall", 32'(s_stall - b_stall), 4);

    // reset in WAIT, then md_rdy
    snap();
    insn_valid = 1; func = F_DIV; rd = 5'd4;
    step();
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    idle_in();
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_stall", 32'(stall), 0);
    chk("t7_div", 32'(ctrl_DIV), 0);
    chk("t7_wbv", 32'(wb_valid), 0);
    chk("t7_wbrd", 32'(wb_rd), 0);
    chk("t7_wbdat", wb_data, 0);
    step();
    md_rdy = 1; md_result = 32'h44;
    step();
    idle_in();
    step();
    step();
    chk("t7_nwb", 32'(s_wb - b_wb), 0);
    chk("t7_busy2", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
